// File: rtl/scan_receiver.sv
// Receives data qualified by a rotating one-hot/one-cold select and assembles full frames.
// Optional idle watchdog is built when SCAN_RECEIVER_TIMEOUT_EN is defined.
//
// state   | meaning
// SYNC    | waiting for a settled capture at index 0 to start a frame
// COLLECT | storing in-order captures until index SIZE-1 completes the frame
module scan_receiver #(
    parameter int SIZE    = 4,
    parameter int DATA_W  = 8,
    parameter int HOT_VAL = 1,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIZE-1:0]          sel,
    input  logic [DATA_W-1:0]        data,
    input  logic                     clr_err,
    output logic [SIZE*DATA_W-1:0]   frame,
    output logic                     frame_valid,
    output logic [((SIZE > 2) ? $clog2(SIZE) : 1)-1:0] index,
    output logic                     err_onehot,
    output logic                     err_order,
    output logic                     err_timeout
);
    localparam int IDX_W = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam int CNT_W = $clog2(SETTLE + 1);

    typedef enum logic {SYNC, COLLECT} state_t;

    state_t                   state;
    logic [SIZE-1:0]          act;
    logic [SIZE-1:0]          prev_act;
    logic [CNT_W-1:0]         stab_cnt;
    logic                     legal;
    logic                     same;
    logic                     capture;
    logic                     order_ev;
    logic                     timeout_ev;
    logic [IDX_W-1:0]         cap_idx;
    logic [IDX_W-1:0]         next_idx;
    logic [SIZE*DATA_W-1:0]   shadow;
    logic [SIZE*DATA_W-1:0]   shadow_upd;

    always_comb begin
        act     = (HOT_VAL != 0) ? sel : ~sel;
        legal   = (act != '0) && ((act & (act - 1'b1)) == '0);
        same    = (act == prev_act);
        // Fires only on the cycle the run length first reaches SETTLE.
        capture = legal && (same ? (stab_cnt == CNT_W'(SETTLE - 1)) : (SETTLE == 1));
        cap_idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (act[i]) cap_idx = IDX_W'(i);
        end
        next_idx   = (index == IDX_W'(SIZE - 1)) ? '0 : index + 1'b1;
        order_ev   = capture && (state == COLLECT) && (cap_idx != next_idx);
        shadow_upd = shadow;
        shadow_upd[int'(cap_idx)*DATA_W +: DATA_W] = data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            prev_act    <= '0;
            stab_cnt    <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            index       <= '0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            prev_act    <= act;
            if (!same) begin
                stab_cnt <= CNT_W'(1);
            end else if (stab_cnt != CNT_W'(SETTLE)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end

            err_onehot <= (err_onehot & ~clr_err) | ~legal;
            err_order  <= (err_order & ~clr_err) | order_ev;

            if (!legal) begin
                state <= SYNC;
            end else if (capture) begin
                case (state)
                    SYNC: begin
                        if (cap_idx == '0) begin
                            shadow <= shadow_upd;
                            index  <= '0;
                            state  <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (cap_idx == next_idx) begin
                            shadow <= shadow_upd;
                            index  <= cap_idx;
                            if (cap_idx == IDX_W'(SIZE - 1)) begin
                                frame       <= shadow_upd;
                                frame_valid <= 1'b1;
                                state       <= SYNC;
                            end
                        end else if (cap_idx == '0) begin
                            shadow <= shadow_upd;
                            index  <= '0;
                        end else begin
                            state <= SYNC;
                        end
                    end
                    default: state <= SYNC;
                endcase
            end else if (timeout_ev) begin
                state <= SYNC;
            end
        end
    end

`ifdef SCAN_RECEIVER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              err_to_q;

    assign timeout_ev  = !capture && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign err_timeout = err_to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            err_to_q <= 1'b0;
        end else begin
            if (capture || timeout_ev) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            err_to_q <= (err_to_q & ~clr_err) | timeout_ev;
        end
    end
`else
    assign timeout_ev  = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_scan_receiver.sv
// Bench for scan_receiver: a one-hot and a one-cold instance driven with equivalent selects,
// checked against a frame-level reference model plus a directed vector table.
module tb_scan_receiver;
    localparam int SETTLE_P  = 2;
    localparam int TIMEOUT_P = 16;
`ifdef SCAN_RECEIVER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sel_h = '0;
    logic [3:0]  sel_c = '1;
    logic [7:0]  data = '0;
    logic        clr_err = 1'b0;

    logic [31:0] frame_h, frame_c;
    logic        fv_h, fv_c;
    logic [1:0]  idx_h, idx_c;
    logic        eh_h, eo_h, et_h, eh_c, eo_c, et_c;

    int checks = 0;
    int errors = 0;

    scan_receiver #(.SIZE(4), .DATA_W(8), .HOT_VAL(1), .SETTLE(SETTLE_P), .TIMEOUT(TIMEOUT_P)) dut_hot (
        .clk(clk), .rst_n(rst_n), .sel(sel_h), .data(data), .clr_err(clr_err),
        .frame(frame_h), .frame_valid(fv_h), .index(idx_h),
        .err_onehot(eh_h), .err_order(eo_h), .err_timeout(et_h)
    );

    scan_receiver #(.SIZE(4), .DATA_W(8), .HOT_VAL(0), .SETTLE(SETTLE_P), .TIMEOUT(TIMEOUT_P)) dut_cold (
        .clk(clk), .rst_n(rst_n), .sel(sel_c), .data(data), .clr_err(clr_err),
        .frame(frame_c), .frame_valid(fv_c), .index(idx_c),
        .err_onehot(eh_c), .err_order(eo_c), .err_timeout(et_c)
    );

    always #5 clk = ~clk;

    // Reference model state: run length of the current select, expected next slot (-1 = waiting for 0)
    logic [3:0]  m_prev;
    int          m_run, m_expect, m_last, m_idle;
    logic [7:0]  m_slot [4];
    logic [31:0] m_frame;
    bit          m_fv, m_eh, m_eo, m_et;

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  data;
        logic        clr;
        logic        fv;
        logic [31:0] frame;
        logic        eo;
        logic        eh;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 0; m_expect = -1; m_last = 0; m_idle = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_frame = '0; m_fv = 0; m_eh = 0; m_eo = 0; m_et = 0;
    endtask

    task automatic model_step(input logic [3:0] s, input logic [7:0] d, input logic c);
        bit legal, cap, e_or, e_to;
        int pos;
        legal = ($countones(s) == 1);
        if (s == m_prev) m_run++; else m_run = 1;
        m_prev = s;
        cap = legal && (m_run == SETTLE_P);
        pos = 0;
        for (int i = 0; i < 4; i++) if (s[i]) pos = i;
        e_or = 0; e_to = 0; m_fv = 0;
        if (TO_EN) begin
            if (cap) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TIMEOUT_P) begin e_to = 1; m_idle = 0; end
            end
        end
        if (!legal) m_expect = -1;
        else if (cap) begin
            if (m_expect < 0) begin
                if (pos == 0) begin m_slot[0] = d; m_last = 0; m_expect = 1; end
            end else if (pos == m_expect) begin
                m_slot[pos] = d; m_last = pos;
                if (pos == 3) begin
                    m_frame = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                    m_fv = 1; m_expect = -1;
                end else m_expect = pos + 1;
            end else begin
                e_or = 1;
                if (pos == 0) begin m_slot[0] = d; m_last = 0; m_expect = 1; end
                else m_expect = -1;
            end
        end
        if (e_to) m_expect = -1;
        m_eh = (m_eh && !c) || !legal;
        m_eo = (m_eo && !c) || e_or;
        m_et = (m_et && !c) || e_to;
    endtask

    task automatic check_model();
        chk("frame_h", frame_h, m_frame);  chk("frame_c", frame_c, m_frame);
        chk("fv_h", 32'(fv_h), 32'(m_fv)); chk("fv_c", 32'(fv_c), 32'(m_fv));
        chk("index_h", 32'(idx_h), 32'(m_last)); chk("index_c", 32'(idx_c), 32'(m_last));
        chk("err_onehot_h", 32'(eh_h), 32'(m_eh)); chk("err_onehot_c", 32'(eh_c), 32'(m_eh));
        chk("err_order_h", 32'(eo_h), 32'(m_eo)); chk("err_order_c", 32'(eo_c), 32'(m_eo));
        chk("err_timeout_h", 32'(et_h), 32'(m_et)); chk("err_timeout_c", 32'(et_c), 32'(m_et));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_frame"}, frame_h | frame_c, 32'h0);
        chk({tag, "_fv"}, 32'(fv_h | fv_c), 32'h0);
        chk({tag, "_index"}, 32'(idx_h | idx_c), 32'h0);
        chk({tag, "_errs"}, 32'({eh_h, eo_h, et_h, eh_c, eo_c, et_c}), 32'h0);
    endtask

    task automatic step(input logic [3:0] s, input logic [7:0] d, input logic c);
        sel_h = s; sel_c = ~s; data = d; clr_err = c;
        @(posedge clk);
        #1;
        model_step(s, d, c);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic row(input logic [3:0] s, input logic [7:0] d, input logic c, input logic fv,
                       input logic [31:0] fr, input logic eo, input logic eh);
        vec_t v;
        v.sel = s; v.data = d; v.clr = c; v.fv = fv; v.frame = fr; v.eo = eo; v.eh = eh;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f1, f2, f3;
        int p;
        f1 = 32'h44332211; f2 = 32'h04030201; f3 = 32'hD4C3B2A1;
        // Clean frame, then hold past the capture point
        row(4'b0001, 8'h11, 0, 0, 0, 0, 0); row(4'b0001, 8'h11, 0, 0, 0, 0, 0);
        row(4'b0010, 8'h22, 0, 0, 0, 0, 0); row(4'b0010, 8'h22, 0, 0, 0, 0, 0);
        row(4'b0100, 8'h33, 0, 0, 0, 0, 0); row(4'b0100, 8'h33, 0, 0, 0, 0, 0);
        row(4'b1000, 8'h44, 0, 0, 0, 0, 0); row(4'b1000, 8'h44, 0, 1, f1, 0, 0);
        row(4'b1000, 8'h44, 0, 0, f1, 0, 0);
        // Skipped slot, recovery frame, then clear
        row(4'b0001, 8'h55, 0, 0, f1, 0, 0); row(4'b0001, 8'h55, 0, 0, f1, 0, 0);
        row(4'b0010, 8'h66, 0, 0, f1, 0, 0); row(4'b0010, 8'h66, 0, 0, f1, 0, 0);
        row(4'b1000, 8'h77, 0, 0, f1, 0, 0); row(4'b1000, 8'h77, 0, 0, f1, 1, 0);
        row(4'b0001, 8'h01, 0, 0, f1, 1, 0); row(4'b0001, 8'h01, 0, 0, f1, 1, 0);
        row(4'b0010, 8'h02, 0, 0, f1, 1, 0); row(4'b0010, 8'h02, 0, 0, f1, 1, 0);
        row(4'b0100, 8'h03, 0, 0, f1, 1, 0); row(4'b0100, 8'h03, 0, 0, f1, 1, 0);
        row(4'b1000, 8'h04, 0, 0, f1, 1, 0); row(4'b1000, 8'h04, 0, 1, f2, 1, 0);
        row(4'b1000, 8'h04, 1, 0, f2, 0, 0);
        // Illegal select mid-frame, then a full frame
        row(4'b0001, 8'hE1, 0, 0, f2, 0, 0); row(4'b0001, 8'hE1, 0, 0, f2, 0, 0);
        row(4'b0010, 8'hE2, 0, 0, f2, 0, 0); row(4'b0010, 8'hE2, 0, 0, f2, 0, 0);
        row(4'b0011, 8'hE3, 0, 0, f2, 0, 1);
        row(4'b0001, 8'hA1, 0, 0, f2, 0, 1); row(4'b0001, 8'hA1, 0, 0, f2, 0, 1);
        row(4'b0010, 8'hB2, 0, 0, f2, 0, 1); row(4'b0010, 8'hB2, 0, 0, f2, 0, 1);
        row(4'b0100, 8'hC3, 0, 0, f2, 0, 1); row(4'b0100, 8'hC3, 0, 0, f2, 0, 1);
        row(4'b1000, 8'hD4, 0, 0, f2, 0, 1); row(4'b1000, 8'hD4, 0, 1, f3, 0, 1);
        row(4'b1000, 8'hD4, 1, 0, f3, 0, 0);

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].sel, tbl[i].data, tbl[i].clr);
            chk("tbl_fv_h", 32'(fv_h), 32'(tbl[i].fv));  chk("tbl_fv_c", 32'(fv_c), 32'(tbl[i].fv));
            chk("tbl_frame_h", frame_h, tbl[i].frame);   chk("tbl_frame_c", frame_c, tbl[i].frame);
            chk("tbl_eo_h", 32'(eo_h), 32'(tbl[i].eo));  chk("tbl_eo_c", 32'(eo_c), 32'(tbl[i].eo));
            chk("tbl_eh_h", 32'(eh_h), 32'(tbl[i].eh));  chk("tbl_eh_c", 32'(eh_c), 32'(tbl[i].eh));
        end

        // Dwell shorter than SETTLE never captures
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b0001 << (i % 4), 8'(8'h90 + i), 0);
            chk("short_fv", 32'(fv_h | fv_c), 32'h0);
            chk("short_index", 32'(idx_h), 32'h0);
        end
        // Reset after slots 0..1 discards the partial frame
        step(4'b0001, 8'h31, 0); step(4'b0001, 8'h31, 0);
        step(4'b0010, 8'h32, 0); step(4'b0010, 8'h32, 0);
        chk("mid_index", 32'(idx_h), 32'h1);
        do_reset();
        for (int i = 2; i < 4; i++) begin
            step(4'b0001 << i, 8'h40, 0); step(4'b0001 << i, 8'h40, 0);
            chk("post_reset_fv", 32'(fv_h), 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            step(4'b0001 << i, 8'(8'h50 + i), 0); step(4'b0001 << i, 8'(8'h50 + i), 0);
        end
        chk("post_reset_frame_fv", 32'(fv_h), 32'h1);
        chk("post_reset_frame", frame_h, 32'h53525150);

        // All-zero select, error beats clear, then idle watchdog
        for (int i = 0; i < 3; i++) step(4'b0000, 8'h00, 0);
        chk("zero_sel_eh", 32'(eh_h), 32'h1);
        step(4'b0000, 8'h00, 1);
        chk("clr_vs_err_eh", 32'(eh_h), 32'h1);
        step(4'b0001, 8'h61, 1);
        chk("clr_eh", 32'(eh_h), 32'h0);
        step(4'b0001, 8'h61, 0);
        for (int i = 0; i < 17; i++) step(4'b0001, 8'h61, 0);
        chk("idle_timeout_h", 32'(et_h), 32'(TO_EN));
        chk("idle_timeout_c", 32'(et_c), 32'(TO_EN));

        // Randomized dwells: mostly in-order, some jumps and illegal patterns
        p = 0;
        for (int n = 0; n < 300; n++) begin
            logic [3:0] s;
            int r, len;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                s = 4'b0001 << p; p = (p + 1) % 4;
            end else if (r < 85) begin
                int q;
                q = $urandom_range(0, 3);
                s = 4'b0001 << q; p = (q + 1) % 4;
            end else begin
                s = 4'(4'b0011 << $urandom_range(0, 2));
                if ($urandom_range(0, 2) == 0) s = 4'b0000;
            end
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++)
                step(s, 8'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_receiver.md
SCAN_RECEIVER -- requirements
Module: scan_receiver

Interface
REQ-001 Parameter SIZE, default 4: number of scan positions; SHALL be 2 or more.
REQ-002 Parameter DATA_W, default 8: width of per-position data.
REQ-003 Parameter HOT_VAL, default 1: 1 means the active select bit is 1 (one-hot); 0 means it is 0 (one-cold).
REQ-004 Parameter SETTLE, default 2: number of consecutive identical legal select cycles required before capture; SHALL be 1 or more.
REQ-005 Parameter TIMEOUT, default 1024: number of idle cycles allowed without a capture (Configuration section only).
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 sel  input  SIZE  scan select from the ring driver; the active bit moves index 0→1→…→SIZE-1→0.
REQ-009 data  input  DATA_W  data qualified by sel.
REQ-010 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-011 frame  output  SIZE*DATA_W  last complete frame; slot i occupies bits [i*DATA_W +: DATA_W].
REQ-012 frame_valid  output  1  one-cycle pulse when frame updates.
REQ-013 index  output  max(1,$clog2(SIZE))  index of the last captured slot.
REQ-014 err_onehot, err_order, err_timeout  output  1 each  sticky error flags.

Function
REQ-015 The block SHALL normalise sel as act = HOT_VAL ? sel : ~sel; act is legal only when exactly one bit is set.
REQ-016 The stability counter SHALL reset to 1 when act differs from the previous cycle's act, otherwise increment, saturating at SETTLE.
REQ-017 Capture SHALL occur exactly once per dwell, on the edge ending the SETTLE-th consecutive cycle of identical legal act: data is written to shadow slot idx(act), and index is set to idx(act).
REQ-018 On an illegal act (zero bits or multiple bits set) for any cycle, the block SHALL set err_onehot, perform no capture, and enter SYNC.
REQ-019 The FSM SHALL have two states. In SYNC, captures are discarded except a capture at index 0, which is stored and moves the FSM to COLLECT.
REQ-020 In COLLECT, a capture at (previous capture index + 1) mod SIZE SHALL be stored. Any other index SHALL set err_order and move the FSM to SYNC. If that index is 0, the FSM SHALL instead restart COLLECT, storing slot 0.
REQ-021 An in-order capture at index SIZE-1 SHALL, on the same edge, copy the complete shadow (including the new slot) to frame, pulse frame_valid high for one cycle, and return the FSM to SYNC.
REQ-022 frame SHALL hold its value between pulses; partial frames SHALL never reach frame.
REQ-023 clr_err SHALL clear all three error flags on the next edge; if an error event occurs in the same cycle, the error SHALL win (flag set).
REQ-024 Select wrap from SIZE-1 to 0 SHALL be treated as the normal in-order successor.

Reset
REQ-025 While rst_n is low: frame=0, frame_valid=0, index=0, all error flags=0, shadow=0, FSM=SYNC, stability counter=0, previous act=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first frame_valid after release requires a full 0..SIZE-1 sequence.

Configuration
REQ-027 Macro SCAN_RECEIVER_TIMEOUT_EN.
- Defined: an idle counter resets on every capture and increments otherwise. On reaching TIMEOUT it sets err_timeout, forces SYNC, and restarts counting.
- Undefined: no idle counter is built and err_timeout is tied to 0.

Verification
REQ-028 SIZE=4, DATA_W=8, SETTLE=2, HOT_VAL=1. Drive sel 0001,0010,0100,1000 with data 11,22,33,44 (hex), 2 cycles each -> frame=0x44332211, frame_valid high for exactly 1 cycle, on the edge ending the 2nd cycle of sel=1000.
REQ-029 HOT_VAL=0. Drive sel 1110,1101,1011,0111 with data A1,B2,C3,D4 -> frame=0xD4C3B2A1, no error flags set.
REQ-030 Sequence 0001,0010,1000 -> err_order=1, no frame_valid. Then a full 0001..1000 sequence -> frame valid. Then clr_err -> err_order=0.
REQ-031 sel=0011 for 1 cycle during a frame -> err_onehot=1 and FSM in SYNC; the next full sequence still produces a frame.
REQ-032 sel held 1 cycle per position (less than SETTLE) -> no captures, index stays 0, no frame_valid. rst_n pulsed low after slots 0..1 are captured -> all outputs 0, then 4 further slots are required for a frame.
REQ-033 With SCAN_RECEIVER_TIMEOUT_EN defined and TIMEOUT=16, hold sel=0000 -> err_onehot=1. Hold a stable legal sel for 17 cycles after capture -> err_timeout=1. With the macro undefined -> err_timeout stays 0.
